// File: rtl/fp64_mul_seq.sv
// Sequencing controller for a binary64 multiplier built around one shared
// HALF_W x HALF_W mantissa multiplier, run over four partial-product passes.
module fp64_mul_seq #(
  parameter int unsigned HALF_W   = 27,
  parameter int unsigned EXP_BIAS = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [63:0]           a,
  input  logic [63:0]           b,
  output logic [HALF_W-1:0]     mul_a,
  output logic [HALF_W-1:0]     mul_b,
  input  logic [2*HALF_W-1:0]   mul_p,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  invalid
);

  localparam int unsigned FRAC_W = 52;
  localparam int unsigned EXPF_W = 11;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned ACC_W  = 2 * MANT_W;
  localparam int unsigned EXP_W  = 13;
  localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    NORM = 3'd5
  } state_t;

  state_t             state;
  logic [62:0]        op_a;
  logic [62:0]        op_b;
  logic               sign_r;
  logic [ACC_W-1:0]   acc;

  // Low and high mantissa halves presented to the shared multiplier.
  function automatic logic [HALF_W-1:0] lo_of(input logic [FRAC_W-1:0] f);
    logic [MANT_W-1:0] m;
    m = {1'b1, f};
    return m[HALF_W-1:0];
  endfunction

  function automatic logic [HALF_W-1:0] hi_of(input logic [FRAC_W-1:0] f);
    logic [MANT_W-1:0] m;
    m = {1'b1, f};
    return HALF_W'(m[MANT_W-1:HALF_W]);
  endfunction

  logic [EXPF_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea     = op_a[62:FRAC_W];
  assign eb     = op_b[62:FRAC_W];
  assign fa     = op_a[FRAC_W-1:0];
  assign fb     = op_b[FRAC_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);

  // Partial product aligned to the weight of the current pass.
  logic [ACC_W-1:0] pp_sh;
  always_comb begin
    pp_sh = '0;
    case (state)
      PP0:      pp_sh = ACC_W'(mul_p);
      PP1, PP2: pp_sh = ACC_W'(mul_p) << HALF_W;
      PP3:      pp_sh = ACC_W'(mul_p) << (2 * HALF_W);
      default:  pp_sh = '0;
    endcase
  end

  logic                     n_inc;
  logic [FRAC_W-1:0]        frac_n;
  logic signed [EXP_W-1:0]  exp_n;
  logic                     unused_acc_lo;

  assign n_inc         = acc[ACC_W-1];
  assign frac_n        = n_inc ? acc[ACC_W-2 -: FRAC_W] : acc[ACC_W-3 -: FRAC_W];
  assign exp_n         = $signed(EXP_W'(ea)) + $signed(EXP_W'(eb))
                       - $signed(EXP_W'(EXP_BIAS)) + $signed(EXP_W'(n_inc));
  assign unused_acc_lo = ^acc[ACC_W-MANT_W-2:0];

  // Final result selection; specials take precedence over range checks.
  logic [63:0] nrm_result;
  logic        nrm_ovf, nrm_unf, nrm_inv;
  always_comb begin
    nrm_result = '0;
    nrm_ovf    = 1'b0;
    nrm_unf    = 1'b0;
    nrm_inv    = 1'b0;
    if (a_nan || b_nan) begin
      nrm_result = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      nrm_result = QNAN;
      nrm_inv    = 1'b1;
    end else if (a_inf || b_inf) begin
      nrm_result = {sign_r, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      nrm_result = {sign_r, 63'b0};
    end else if (exp_n >= 13'sd2047) begin
      nrm_result = {sign_r, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
      nrm_ovf    = 1'b1;
    end else if (exp_n <= 13'sd0) begin
      nrm_result = {sign_r, 63'b0};
      nrm_unf    = 1'b1;
    end else begin
      nrm_result = {sign_r, exp_n[EXPF_W-1:0], frac_n};
    end
  end

  // Control FSM; multiplier operands are loaded one cycle ahead of each pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sign_r    <= 1'b0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= a[62:0];
            op_b      <= b[62:0];
            sign_r    <= a[63] ^ b[63];
            acc       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            busy      <= 1'b1;
            mul_a     <= lo_of(a[FRAC_W-1:0]);
            mul_b     <= lo_of(b[FRAC_W-1:0]);
            state     <= PP0;
          end
        end
        PP0: begin
          acc   <= acc + pp_sh;
          mul_a <= lo_of(fa);
          mul_b <= hi_of(fb);
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + pp_sh;
          mul_a <= hi_of(fa);
          mul_b <= lo_of(fb);
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + pp_sh;
          mul_a <= hi_of(fa);
          mul_b <= hi_of(fb);
          state <= PP3;
        end
        PP3: begin
          acc   <= acc + pp_sh;
          mul_a <= '0;
          mul_b <= '0;
          state <= NORM;
        end
        NORM: begin
          result    <= nrm_result;
          overflow  <= nrm_ovf;
          underflow <= nrm_unf;
          invalid   <= nrm_inv;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_mul_seq.sv
// Directed self-checking bench for fp64_mul_seq with a behavioural shared multiplier.
module tb_fp64_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] a, b;
  logic [26:0] mul_a, mul_b;
  logic [53:0] mul_p;
  logic        busy, done, overflow, underflow, invalid;
  logic [63:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  assign mul_p = {27'b0, mul_a} * {27'b0, mul_b};

  always #5 clk = ~clk;

  fp64_mul_seq #(.HALF_W(27), .EXP_BIAS(1023)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Pulse start for one sampling edge; returns with inputs released just after it.
  task automatic pulse_start(input logic [63:0] ta, input logic [63:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the number of edges after the start edge.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic [63:0] er, input logic eo, input logic eu, input logic ei);
    int lat;
    logic [63:0] held;
    pulse_start(ta, tb_v);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_result"}, result, er);
    chk({tag, "_overflow"}, 64'(overflow), 64'(eo));
    chk({tag, "_underflow"}, 64'(underflow), 64'(eu));
    chk({tag, "_invalid"}, 64'(invalid), 64'(ei));
    held = result;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_held"}, result, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    logic [63:0] first_res;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_flags", {61'b0, overflow, underflow, invalid}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Per-pass operand schedule: lo_a=3, lo_b=0, hi_a=hi_b=2^25.
    pulse_start(64'h3FF0_0000_0000_0003, 64'h3FF0_0000_0000_0000);
    chk("pp0_mul_a", 64'(mul_a), 64'h3);
    chk("pp0_mul_b", 64'(mul_b), 64'h0);
    chk("pp0_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("pp1_mul_a", 64'(mul_a), 64'h3);
    chk("pp1_mul_b", 64'(mul_b), 64'h200_0000);
    @(posedge clk); #1;
    chk("pp2_mul_a", 64'(mul_a), 64'h200_0000);
    chk("pp2_mul_b", 64'(mul_b), 64'h0);
    @(posedge clk); #1;
    chk("pp3_mul_a", 64'(mul_a), 64'h200_0000);
    chk("pp3_mul_b", 64'(mul_b), 64'h200_0000);
    @(posedge clk); #1;
    chk("norm_mul_a", 64'(mul_a), 64'h0);
    chk("norm_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("sched_done", 64'(done), 64'd1);
    chk("sched_busy", 64'(busy), 64'd0);
    chk("sched_result", result, 64'h3FF0_0000_0000_0003);

    run_op("one_x_one", 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("bump", 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000,
           64'h4002_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("neg", 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000,
           64'hC018_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("ovf", 64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000,
           64'h7FF0_0000_0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("unf", 64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000,
           64'h0000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("inf_zero", 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000,
           64'h7FF8_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    run_op("denorm", 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001,
           64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("nan", 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
           64'h7FF8_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("neg_inf", 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
           64'hFFF0_0000_0000_0000, 1'b0, 1'b0, 1'b0);

    // Second start during PP1 must be ignored.
    pulse_start(64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    @(posedge clk); #1;
    a = 64'h4000_0000_0000_0000; b = 64'h4000_0000_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; lat = 0; first_res = '0;
    for (int i = 3; i <= 15; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (dones == 0) begin
          lat = i;
          first_res = result;
        end
        dones++;
      end
    end
    chk("ign_done_count", 64'(dones), 64'd1);
    chk("ign_latency", 64'(lat), 64'd5);
    chk("ign_result", first_res, 64'h4002_0000_0000_0000);

    // Reset during PP2 discards the operation.
    pulse_start(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_mul_a", 64'(mul_a), 64'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("mid_rst_no_done", 64'(dones), 64'd0);
    run_op("after_rst", 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000,
           64'hC018_0000_0000_0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back: new start raised in the done cycle.
    pulse_start(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000);
    wait_done(lat);
    chk("b2b_first_latency", 64'(lat), 64'd5);
    chk("b2b_first_result", result, 64'hC018_0000_0000_0000);
    a = 64'h3FF8_0000_0000_0000; b = 64'h3FF8_0000_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted_busy", 64'(busy), 64'd1);
    chk("b2b_done_drop", 64'(done), 64'd0);
    wait_done(lat);
    chk("b2b_second_latency", 64'(lat), 64'd5);
    chk("b2b_second_result", result, 64'h4002_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
